// File: rtl/header_capture_fifo_pkg.sv
// Shared constants for the header capture path: default widths and the
// statistic register offsets used when the counters are mapped onto the register ring.
package header_capture_fifo_pkg;

   localparam int OF_HEADER_REG_WIDTH = 64;
   localparam int STAT_CNT_WIDTH      = 32;

   typedef enum logic [1:0] {
      STAT_CAPTURED = 2'd0,
      STAT_DROPPED  = 2'd1,
      STAT_FILL     = 2'd2
   } stat_reg_e;

endpackage

// File: rtl/hdr_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is held in a register that is
// loaded from the storage array, so a write into an empty FIFO is visible one cycle later.
module hdr_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_rd, do_wr;

   always_comb begin
      do_rd    = rd_en_i & (count_q != '0);
      do_wr    = wr_en_i & ((count_q != FULL_CNT) | do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // The slot becoming the head may be the one being written this cycle.
      if (do_wr && (wr_ptr_q == rd_ptr_d)) head_d = wr_data_i;
      else                                  head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = head_q;
   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;

endmodule

// File: rtl/header_capture_fifo.sv
// Captures one header per rising edge of headers_valid into a FWFT FIFO and keeps
// capture/drop statistics so lookup back-pressure never stalls the parser.
module header_capture_fifo
   import header_capture_fifo_pkg::*;
#(
   parameter int HDR_WIDTH = OF_HEADER_REG_WIDTH,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = STAT_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [HDR_WIDTH-1:0]     header_bus,
   input  logic                     headers_valid,
   output logic [HDR_WIDTH-1:0]     out_header,
   output logic                     out_valid,
   input  logic                     out_rdy,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [CNT_WIDTH-1:0]     num_captured,
   output logic [CNT_WIDTH-1:0]     num_dropped,
   output logic                     overflow
);

   logic                 hv_q;
   logic                 cap, pop, accept, drop;
   logic                 full, empty;
   logic [CNT_WIDTH-1:0] captured_q, captured_d;
   logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
   logic                 overflow_q;

   always_comb begin
      cap        = headers_valid & ~hv_q;
      pop        = ~empty & out_rdy;
      accept     = cap & (~full | pop);
      drop       = cap & full & ~pop;
      captured_d = captured_q;
      dropped_d  = dropped_q;
      if (accept) captured_d = captured_q + 1'b1;
      if (drop)   dropped_d  = dropped_q + 1'b1;
   end

   // hv_q resets high so a header already valid at reset release is never captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         hv_q       <= 1'b1;
         captured_q <= '0;
         dropped_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         hv_q       <= headers_valid;
         captured_q <= captured_d;
         dropped_q  <= dropped_d;
         overflow_q <= drop;
      end
   end

   hdr_sync_fifo #(
      .WIDTH (HDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (accept),
      .wr_data_i (header_bus),
      .rd_en_i   (out_rdy),
      .rd_data_o (out_header),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (fill_level)
   );

   assign out_valid    = ~empty;
   assign num_captured = captured_q;
   assign num_dropped  = dropped_q;
   assign overflow     = overflow_q;

endmodule
